// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
//
// Purpose: one valid/ready memory request channel (16-bit address and data,
// 2-bit byte strobes). The same channel is used on both sides of the arbiter:
// from each requesting master into the arbiter, and from the arbiter out to
// the memory.
//
// Signals:
//   valid  request present; held with stable fields until ready
//   addr   16-bit address
//   wstrb  byte strobes; 2'b00 means read
//   wdata  16-bit write data
//   ready  one-cycle completion from the responder
//   rdata  16-bit read data, valid with ready
//
// Modports:
//   master  drives the request, receives the completion
//   slave   receives the request, drives the completion
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;
  logic        valid;
  logic [15:0] addr;
  logic [1:0]  wstrb;
  logic [15:0] wdata;
  logic        ready;
  logic [15:0] rdata;

  modport master (output valid, addr, wstrb, wdata, input ready, rdata);
  modport slave  (input valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose: shares one 16-bit memory port between master 0 (core) and
// master 1 (loader/DMA/debug). The winning request is registered onto the
// memory port. The completion is routed back to the owning master only.
// Under contention, grants alternate round-robin.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a slave-response
// watchdog. After TIMEOUT_CYCLES cycles in an ownership state without
// s.ready, the arbiter aborts the transfer. It completes it to the owner
// with rdata 16'hFFFF and pulses timeout_err. With the macro undefined, the
// arbiter waits indefinitely and timeout_err is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit, 1..65535 (used only with MEM_ARB_TIMEOUT_EN)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   m0           master 0 request channel (arbiter is the slave side)
//   m1           master 1 request channel (arbiter is the slave side)
//   s            memory channel (arbiter is the master side); registered fields
//   grant        one-hot current owner, registered; 2'b00 when idle
//   timeout_err  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_bus_arbiter_if.slave        m0,
  mem_bus_arbiter_if.slave        m1,
  mem_bus_arbiter_if.master       s,
  output logic [1:0]              grant,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;          // master served most recently
  logic [1:0]  grant_q, grant_d;
  logic        s_valid_q, s_valid_d;
  logic [15:0] s_addr_q, s_addr_d;
  logic [1:0]  s_wstrb_q, s_wstrb_d;
  logic [15:0] s_wdata_q, s_wdata_d;

  logic        done;         // current transfer ends this cycle
  logic        abort;        // ... and it ends by watchdog, not by the slave
  logic        wd_expired;
  logic [15:0] resp_data;

  // ---------------------------------------------------------------------------
  // Next-state and request capture
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    s_valid_d = s_valid_q;
    s_addr_d  = s_addr_q;
    s_wstrb_d = s_wstrb_q;
    s_wdata_d = s_wdata_q;
    done      = 1'b0;
    abort     = 1'b0;

    case (state_q)
      IDLE: begin
        // Master 0 wins when it is alone. On a tie, it wins if master 1 was
        // served last.
        if (m0.valid && (!m1.valid || last_q)) begin
          state_d   = OWN0;
          grant_d   = 2'b01;
          s_valid_d = 1'b1;
          s_addr_d  = m0.addr;
          s_wstrb_d = m0.wstrb;
          s_wdata_d = m0.wdata;
        end else if (m1.valid) begin
          state_d   = OWN1;
          grant_d   = 2'b10;
          s_valid_d = 1'b1;
          s_addr_d  = m1.addr;
          s_wstrb_d = m1.wstrb;
          s_wdata_d = m1.wdata;
        end
      end

      OWN0, OWN1: begin
        // Request inputs are ignored while owned; only the slave or the
        // watchdog can end the transfer. A real response beats a
        // simultaneous watchdog expiry.
        if (s.ready) begin
          done = 1'b1;
        end else if (wd_expired) begin
          done  = 1'b1;
          abort = 1'b1;
        end

        if (done) begin
          state_d   = IDLE;
          last_d    = (state_q == OWN1);
          grant_d   = 2'b00;
          s_valid_d = 1'b0;
          s_wstrb_d = 2'b00;
          s_wdata_d = 16'h0000;
          if (abort) begin
            s_addr_d = 16'h0000;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        grant_d   = 2'b00;
        s_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the reset is asynchronous. Outputs clear as soon as rst_n falls,
  // so an in-flight transfer is dropped with no completion to either master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      s_valid_q <= 1'b0;
      s_addr_q  <= 16'h0000;
      s_wstrb_q <= 2'b00;
      s_wdata_q <= 16'h0000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      s_valid_q <= s_valid_d;
      s_addr_q  <= s_addr_d;
      s_wstrb_q <= s_wstrb_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Slave-response watchdog
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
  // The count is 0 in the first ownership cycle. The limit is therefore
  // hit in cycle TIMEOUT_CYCLES of the ownership state.
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (state_q == IDLE || done) begin
      wd_d = 16'h0000;
    end else begin
      wd_d = wd_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= 16'h0000;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign wd_expired  = (state_q != IDLE) && (wd_q == WD_LIMIT);
  assign timeout_err = abort;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expired         = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s.valid = s_valid_q;
  assign s.addr  = s_addr_q;
  assign s.wstrb = s_wstrb_q;
  assign s.wdata = s_wdata_q;
  assign grant   = grant_q;

  // The completion path is combinational from the slave. It is gated by
  // grant_q, so only the owner ever sees ready or data.
  assign resp_data = abort ? 16'hFFFF : s.rdata;
  assign m0.ready  = done & grant_q[0];
  assign m1.ready  = done & grant_q[1];
  assign m0.rdata  = grant_q[0] ? resp_data : 16'h0000;
  assign m1.rdata  = grant_q[1] ? resp_data : 16'h0000;

endmodule
